mealy_pattern_source: RTL and testbench

Serial pattern transmitter, the driving end of the serial line that the Mealy pattern detector samples. It accepts 2-bit symbol commands through a valid/ready handshake and buffers them in a small FIFO. It serialises each command as a 3-bit pattern on a single output bit, one bit per clock. It also emits a per-symbol marker that is aligned with the last bit of each symbol, so benches and downstream checkers can line up the detector's expected output with the stream.

---
 rtl/mealy_pattern_source_if.sv | 9 +
 rtl/mealy_pattern_source.sv | 180 ++++++++++++++++++
 tb/tb_mealy_pattern_source.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mealy_pattern_source_if.sv
// Command channel of mealy_pattern_source: 2-bit symbol codes with valid/ready handshake.
interface mealy_pattern_source_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/mealy_pattern_source.sv
// Serial 3-bit pattern transmitter with command FIFO and per-symbol last-bit marker.
// Optional MEALY_PATTERN_SOURCE_ERR_EN: 2'b11 commands are dropped and flagged on a sticky err.
module mealy_pattern_source #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    mealy_pattern_source_if.slave   cmd_if,
    output logic                    o,
    output logic                    busy,
    output logic                    sym_last,
    output logic [1:0]              sym_code,
    output logic                    err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_n;
    logic               o_n;
    logic               busy_n;
    logic               sym_last_n;
    logic [1:0]         sym_code_n;

    logic [1:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_n;

    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [1:0]         head;
    logic [2:0]         head_pat;
    logic [2:0]         cur_pat;

    // Bit pattern for a symbol code; bit 2 goes on the line first.
    function automatic logic [2:0] pattern_of(input logic [1:0] code);
        case (code)
            2'b10:   return 3'b111;
            2'b01:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
    assign cmd_if.cmd_ready = reset_n && (count < CNT_W'(DEPTH));
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;

`ifdef MEALY_PATTERN_SOURCE_ERR_EN
    assign push = accept && (cmd_if.cmd != 2'b11);
`else
    assign push = accept;
`endif

    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign head_pat   = pattern_of(head);
    assign cur_pat    = pattern_of(sym_code);

    // Next-state and registered-output decode.
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        o_n        = o;
        busy_n     = busy;
        sym_last_n = sym_last;
        sym_code_n = sym_code;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_n    = SEND;
                    bit_idx_n  = '0;
                    o_n        = head_pat[2];
                    busy_n     = 1'b1;
                    sym_last_n = 1'b0;
                    sym_code_n = head;
                end
            end
            SEND: begin
                if (bit_idx != IDX_W'(2)) begin
                    bit_idx_n  = bit_idx + IDX_W'(1);
                    o_n        = (bit_idx == '0) ? cur_pat[1] : cur_pat[0];
                    sym_last_n = (bit_idx == IDX_W'(1));
                end else if (!fifo_empty) begin
                    // Back-to-back symbol: reload without an idle bit.
                    pop        = 1'b1;
                    bit_idx_n  = '0;
                    o_n        = head_pat[2];
                    sym_last_n = 1'b0;
                    sym_code_n = head;
                end else begin
                    state_n    = IDLE;
                    bit_idx_n  = '0;
                    o_n        = 1'b0;
                    busy_n     = 1'b0;
                    sym_last_n = 1'b0;
                    sym_code_n = 2'b00;
                end
            end
            default: begin
                state_n    = IDLE;
                bit_idx_n  = '0;
                o_n        = 1'b0;
                busy_n     = 1'b0;
                sym_last_n = 1'b0;
                sym_code_n = 2'b00;
            end
        endcase
    end

    assign count_n = count + CNT_W'(push) - CNT_W'(pop);

    // State, line outputs and FIFO bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_idx  <= '0;
            o        <= 1'b0;
            busy     <= 1'b0;
            sym_last <= 1'b0;
            sym_code <= 2'b00;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            o        <= o_n;
            busy     <= busy_n;
            sym_last <= sym_last_n;
            sym_code <= sym_code_n;
            count    <= count_n;
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= cmd_if.cmd;
        end
    end

`ifdef MEALY_PATTERN_SOURCE_ERR_EN
    // Sticky until reset once an illegal code has been handshaken.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept && (cmd_if.cmd == 2'b11)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mealy_pattern_source.sv
// Scoreboard bench for mealy_pattern_source: cycle-stamped expected bits checked by a monitor.
module tb_mealy_pattern_source;

    localparam int unsigned DEPTH = 4;
`ifdef MEALY_PATTERN_SOURCE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       o;
    logic       busy;
    logic       sym_last;
    logic [1:0] sym_code;
    logic       err;

    mealy_pattern_source_if bus ();

    mealy_pattern_source #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cmd_if   (bus.slave),
        .o        (o),
        .busy     (busy),
        .sym_last (sym_last),
        .sym_code (sym_code),
        .err      (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic       bit_v;
        logic       last;
        logic [1:0] code;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int       starts[$];
    int       cyc       = 0;
    int       last_end  = 0;
    logic     exp_err   = 1'b0;
    int       n_checks  = 0;
    int       n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] pattern(input logic [1:0] c);
        logic [2:0] tbl [4];
        tbl = '{3'b000, 3'b001, 3'b111, 3'b000};
        return tbl[c];
    endfunction

    // Symbols still buffered after edge c: those whose first bit starts later than c.
    function automatic int pending_after(input int c);
        int n = 0;
        foreach (starts[i]) if (starts[i] > c) n++;
        return n;
    endfunction

    // Reference model: each accepted symbol occupies the three cycles after the later of
    // its acceptance edge and the end of the previous symbol.
    initial forever begin
        int         st;
        logic [2:0] p;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            starts.delete();
            last_end = cyc;
            exp_err  = 1'b0;
        end else if (bus.cmd_valid && (pending_after(cyc - 1) < int'(DEPTH))) begin
            if (ERR_EN && (bus.cmd == 2'b11)) begin
                exp_err = 1'b1;
            end else begin
                st = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
                p  = pattern(bus.cmd);
                for (int j = 0; j < 3; j++) begin
                    exp_q.push_back('{cyc: st + j, bit_v: p[2 - j], last: (j == 2), code: bus.cmd});
                end
                last_end = st + 2;
                starts.push_back(st);
            end
        end
        while (starts.size() != 0 && starts[0] < cyc - 1) void'(starts.pop_front());
    end

    // Monitor: pops the expected bit due in this cycle, otherwise requires an idle line.
    initial forever begin
        exp_bit_t e;
        @(negedge clock);
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("busy", 32'(busy), 32'(1'b1));
            check("o", 32'(o), 32'(e.bit_v));
            check("sym_last", 32'(sym_last), 32'(e.last));
            check("sym_code", 32'(sym_code), 32'(e.code));
        end else begin
            check("idle_busy", 32'(busy), 32'(1'b0));
            check("idle_o", 32'(o), 32'(1'b0));
            check("idle_sym_last", 32'(sym_last), 32'(1'b0));
            check("idle_sym_code", 32'(sym_code), 32'(2'b00));
        end
        check("cmd_ready", 32'(bus.cmd_ready),
              32'(reset_n && (pending_after(cyc) < int'(DEPTH))));
        check("err", 32'(err), 32'(exp_err));
    end

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] c);
        int   n = 0;
        logic acc;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        do begin
            acc = bus.cmd_ready;
            @(negedge clock);
            #1;
            n++;
        end while (!acc && n < 100);
        check("send_accepted", 32'(acc), 32'(1'b1));
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] burst [4];
        logic [1:0] fill  [8];
        int         w;
        burst = '{2'b10, 2'b01, 2'b10, 2'b00};
        fill  = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};

        // Reset held two cycles with a command offered.
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'b10;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset_n       = 1'b1;
        bus.cmd_valid = 1'b0;
        idle(3);

        send(2'b01);
        idle(6);

        foreach (burst[i]) send(burst[i]);
        idle(15);

        foreach (fill[i]) send(fill[i]);
        idle(30);

        send(2'b11);
        send(2'b10);
        idle(8);

        repeat (60) begin
            idle(int'($urandom_range(0, 2)));
            send(2'($urandom_range(0, 3)));
        end
        idle(40);

        // Reset lands on the edge that would present the third bit of 1,1,1.
        send(2'b10);
        send(2'b01);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        idle(10);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
